// File: rtl/display_scan_ctrl.sv
// Seven-segment scan scheduler: walks the active digits through guard (dark) and
// dwell (lit) slots, showing a per-frame snapshot with leading-zero suppression.
module display_scan_ctrl #(
  parameter int DWELL_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        rs_en,
  input  logic        lz_en,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  output logic [2:0]  digit_sel,
  output logic [3:0]  digit_val,
  output logic        dp,
  output logic        blank,
  output logic        frame_tick
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GUARD,
    ST_DWELL
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    sel_d;
  logic [31:0]   snap, snap_d;
  logic [7:0]    snap_dp, snap_dp_d;
  logic          mode_q;
  logic          en;
  logic [2:0]    last;
  logic          tick_d;
  logic          blank_d;

  // Suppressed when every snapshot digit from i up to the last scanned one is zero.
  function automatic logic supp_f(input logic [2:0] i, input logic [31:0] s,
                                  input logic [2:0] lst, input logic lz);
    logic all_zero;
    all_zero = 1'b1;
    for (int k = 1; k < 8; k++) begin
      if (k >= int'(i) && k <= int'(lst) && s[k*4 +: 4] != 4'd0) all_zero = 1'b0;
    end
    return lz && (i != 3'd0) && all_zero;
  endfunction

  always_comb begin
    en        = mode | rs_en;
    last      = mode ? 3'd2 : 3'd3;
    state_d   = state;
    cnt_d     = cnt;
    sel_d     = digit_sel;
    snap_d    = snap;
    snap_dp_d = snap_dp;
    tick_d    = 1'b0;
    blank_d   = 1'b1;

    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else if (mode != mode_q || state == ST_OFF) begin
      // A mode switch restarts the frame so a stale 4th-digit slot never shows.
      state_d = ST_GUARD;
      sel_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
            if (digit_sel == 3'd0) begin
              snap_d    = digits_in;
              snap_dp_d = dp_in;
              tick_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        ST_DWELL: begin
          if (cnt == DWELL_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            sel_d   = (digit_sel >= last) ? 3'd0 : digit_sel + 3'd1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    if (state_d == ST_DWELL) blank_d = supp_f(sel_d, snap_d, last, lz_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      cnt        <= '0;
      digit_sel  <= 3'd0;
      snap       <= 32'd0;
      snap_dp    <= 8'd0;
      mode_q     <= 1'b0;
      digit_val  <= 4'd0;
      dp         <= 1'b0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      digit_sel  <= sel_d;
      snap       <= snap_d;
      snap_dp    <= snap_dp_d;
      mode_q     <= mode;
      digit_val  <= snap_d[{sel_d, 2'b00} +: 4];
      dp         <= snap_dp_d[sel_d];
      blank      <= blank_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL_CYCLES=4, GUARD_CYCLES=2:
// a vector table sampled N edges after reset, plus multi-cycle corner sequences.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        rs_en;
  logic        lz_en;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [2:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        dp;
  logic        blank;
  logic        frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

  display_scan_ctrl #(.DWELL_CYCLES(4), .GUARD_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .rs_en      (rs_en),
    .lz_en      (lz_en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .digit_sel  (digit_sel),
    .digit_val  (digit_val),
    .dp         (dp),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        rs_en;
    logic        lz_en;
    logic [31:0] digits;
    logic [7:0]  dpin;
    int          edges;
    logic [2:0]  sel;
    logic [3:0]  val;
    logic        dp;
    logic        blank;
    logic        tick;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Leaves the bench on a falling edge with reset just released; edge 1 is the next rising edge.
  task automatic do_reset(input logic m, input logic rs, input logic lz,
                          input logic [31:0] d, input logic [7:0] p);
    @(negedge clk);
    rst_n     = 1'b0;
    mode      = m;
    rs_en     = rs;
    lz_en     = lz;
    digits_in = d;
    dp_in     = p;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic [3:0] v,
                         input logic b, input logic t);
    chk({tag, ".sel"},   32'(digit_sel),  32'(s));
    chk({tag, ".val"},   32'(digit_val),  32'(v));
    chk({tag, ".blank"}, 32'(blank),      32'(b));
    chk({tag, ".tick"},  32'(frame_tick), 32'(t));
  endtask

  initial begin
    int ticks;
    int saw3;
    rst_n = 1'b0; mode = 1'b1; rs_en = 1'b0; lz_en = 1'b0; digits_in = '0; dp_in = '0;

    //           mode rs lz digits        dp     edge sel val dp blk tick
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02,  0, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02,  2, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02,  3, 0, 3, 0, 0, 1});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02,  6, 0, 3, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02,  7, 1, 2, 1, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02,  9, 1, 2, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02, 15, 2, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02, 19, 0, 3, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 32'h00000123, 8'h02, 21, 0, 3, 0, 0, 1});
    vecs.push_back('{0, 1, 1, 32'h00000045, 8'h00,  3, 0, 5, 0, 0, 1});
    vecs.push_back('{0, 1, 1, 32'h00000045, 8'h00,  9, 1, 4, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 32'h00000045, 8'h00, 15, 2, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 32'h00000045, 8'h00, 21, 3, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 32'h00000045, 8'h00, 27, 0, 5, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 32'h00000045, 8'h00, 15, 2, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 32'h00000045, 8'h00, 21, 3, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 32'h00000045, 8'hFF,  5, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 32'h00000405, 8'h00,  9, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 32'h00000405, 8'h00, 15, 2, 4, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 32'h00000405, 8'h00, 21, 3, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 1, 32'h00003005, 8'h00,  9, 1, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 1, 32'h00003005, 8'h01,  3, 0, 5, 1, 0, 1});

    foreach (vecs[i]) begin
      do_reset(vecs[i].mode, vecs[i].rs_en, vecs[i].lz_en, vecs[i].digits, vecs[i].dpin);
      run(vecs[i].edges);
      chk_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].val, vecs[i].blank, vecs[i].tick);
      chk($sformatf("vec%0d.dp", i), 32'(dp), 32'(vecs[i].dp));
    end

    // Mode 1 long run: one frame_tick per 18 cycles, digit 3 never selected.
    do_reset(1, 0, 0, 32'h00000123, 8'h00);
    ticks = 0;
    saw3  = 0;
    for (int c = 0; c < 60; c++) begin
      run(1);
      if (frame_tick) ticks++;
      if (digit_sel == 3'd3) saw3++;
    end
    chk("m1_ticks", 32'(ticks), 32'd4);
    chk("m1_no_sel3", 32'(saw3), 32'd0);

    // Tear-free: live data changes while digit 2 dwells; frame finishes on old snapshot.
    do_reset(0, 1, 0, 32'h00001234, 8'h00);
    run(15);
    chk_out("tear_d2", 2, 2, 0, 0);
    digits_in = 32'h00005678;
    run(6);
    chk_out("tear_d3", 3, 1, 0, 0);
    run(6);
    chk_out("tear_n0", 0, 8, 0, 1);
    run(6);
    chk_out("tear_n1", 1, 7, 0, 0);
    run(6);
    chk_out("tear_n2", 2, 6, 0, 0);
    run(6);
    chk_out("tear_n3", 3, 5, 0, 0);

    // Disable mid-dwell, then re-enable.
    do_reset(0, 1, 0, 32'h00001234, 8'h00);
    run(10);
    chk("dis_pre.sel", 32'(digit_sel), 32'd1);
    chk("dis_pre.blank", 32'(blank), 32'd0);
    rs_en = 1'b0;
    run(1);
    chk("dis_e1.blank", 32'(blank), 32'd1);
    run(8);
    chk("dis_e9.blank", 32'(blank), 32'd1);
    chk("dis_e9.tick", 32'(frame_tick), 32'd0);
    rs_en = 1'b1;
    run(1);
    chk_out("reen_g", 0, 4, 1, 0);
    run(2);
    chk_out("reen_d", 0, 4, 0, 1);

    // Mode toggle 0->1 while digit 3 dwells.
    do_reset(0, 1, 0, 32'h00001234, 8'h00);
    run(22);
    chk_out("tog_pre", 3, 1, 0, 0);
    mode = 1'b1;
    run(1);
    chk("tog_e1.sel", 32'(digit_sel), 32'd0);
    chk("tog_e1.blank", 32'(blank), 32'd1);
    run(2);
    chk_out("tog_d0", 0, 4, 0, 1);
    saw3 = 0;
    for (int c = 0; c < 40; c++) begin
      run(1);
      if (digit_sel == 3'd3) saw3++;
    end
    chk("tog_no_sel3", 32'(saw3), 32'd0);

    // Mode 1->0 with rs_en=0: en falls together with the mode change, disable wins.
    do_reset(1, 0, 0, 32'h00001234, 8'h00);
    run(4);
    chk("both_pre.blank", 32'(blank), 32'd0);
    mode = 1'b0;
    run(1);
    chk("both_e1.blank", 32'(blank), 32'd1);
    run(8);
    chk("both_e9.blank", 32'(blank), 32'd1);

    // Async reset mid-dwell of digit 2, checked between clock edges.
    do_reset(1, 0, 0, 32'h00000123, 8'h04);
    run(16);
    chk_out("ar_pre", 2, 1, 0, 0);
    chk("ar_pre.dp", 32'(dp), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("ar_now", 0, 0, 1, 0);
    chk("ar_now.dp", 32'(dp), 32'd0);
    @(negedge clk);
    digits_in = 32'h00000789;
    rst_n = 1'b1;
    run(3);
    chk_out("ar_fresh", 0, 9, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
